// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the sequential Booth significand multiplier.
// Radix-4 digit recoding lives here so the datapath and any checker agree on it.
package fp_mul_pkg;

  localparam int unsigned MANT_W = 24;
  localparam int unsigned FRAC_W = MANT_W - 1;
  localparam int unsigned TAG_W  = 20;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

  typedef logic signed [2:0] booth_digit_t;

  // Overlapping triplet {q[i+1], q[i], q[i-1]} -> digit in {-2..+2}.
  function automatic booth_digit_t booth_decode(input logic [2:0] bits);
    booth_digit_t digit;
    case (bits)
      3'b001, 3'b010: digit = 3'sd1;
      3'b011:         digit = 3'sd2;
      3'b100:         digit = -3'sd2;
      3'b101, 3'b110: digit = -3'sd1;
      default:        digit = 3'sd0;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/fp_booth_pp_sel.sv
// Radix-4 Booth partial-product selector: digit(q_lsb_i) * m_i, as a signed
// value wide enough to hold +/-2M without overflow.
module fp_booth_pp_sel #(
  parameter int unsigned MANT_W = 24
) (
  input  logic [MANT_W-1:0] m_i,
  input  logic [2:0]        q_lsb_i,
  output logic [MANT_W+2:0] pp_o
);
  import fp_mul_pkg::*;

  booth_digit_t      digit;
  logic [MANT_W+2:0] m_x1;
  logic [MANT_W+2:0] m_x2;

  always_comb begin
    digit = booth_decode(q_lsb_i);
    m_x1  = {3'b000, m_i};
    m_x2  = {2'b00, m_i, 1'b0};
    case (digit)
      3'sd1:   pp_o = m_x1;
      3'sd2:   pp_o = m_x2;
      -3'sd1:  pp_o = -m_x1;
      -3'sd2:  pp_o = -m_x2;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/fp_mul_booth_seq.sv
// Sequential radix-4 Booth significand multiplier, one digit per cycle, with an
// opaque sideband tag carried alongside so downstream stages see it aligned.
module fp_mul_booth_seq #(
  parameter int unsigned MANT_W = fp_mul_pkg::MANT_W,
  parameter int unsigned TAG_W  = fp_mul_pkg::TAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                hid_X,
  input  logic [MANT_W-2:0]   frc_X,
  input  logic                hid_Y,
  input  logic [MANT_W-2:0]   frc_Y,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*MANT_W-1:0] frc_Z_full,
  output logic                norm_n,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);
  import fp_mul_pkg::*;

  localparam int unsigned NUM_DIGITS = (MANT_W + 2) / 2;
  localparam int unsigned PW         = MANT_W + 3;
  localparam int unsigned CntW       = $clog2(NUM_DIGITS);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_DIGITS - 1);

  mul_state_t          state_q, state_d;
  logic [MANT_W-1:0]   m_q, m_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [PW-1:0]       mq_q, mq_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [2*MANT_W-1:0] prod_q, prod_d;

  logic [PW-1:0]          pp;
  logic [PW-1:0]          sum;
  logic signed [2*PW-1:0] pair_sh;
  logic [2*PW-2:0]        prod_full;
  logic                   accept;
  logic                   unused_prod_hi;

  fp_booth_pp_sel #(
    .MANT_W (MANT_W)
  ) u_pp_sel (
    .m_i     (m_q),
    .q_lsb_i (mq_q[2:0]),
    .pp_o    (pp)
  );

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == BUSY);
  assign frc_Z_full = prod_q;
  assign norm_n     = prod_q[2*MANT_W-1];
  assign out_tag    = tag_q;
  assign accept     = in_valid && in_ready;

  always_comb begin
    sum       = acc_q + pp;
    pair_sh   = $signed({sum, mq_q}) >>> 2;
    // The product sits one bit above the bottom because mq_q[0] is the Booth bit.
    prod_full = pair_sh[2*PW-1:1];

    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    prod_d  = prod_q;

    unique case (state_q)
      IDLE: ;
      BUSY: begin
        acc_d = pair_sh[2*PW-1:PW];
        mq_d  = pair_sh[PW-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = DONE;
          prod_d  = prod_full[2*MANT_W-1:0];
        end
      end
      DONE: begin
        if (out_ready && !in_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Zero-extend the multiplier by two bits so the top digit is never negative.
    if (accept) begin
      state_d = BUSY;
      m_d     = {hid_X, frc_X};
      mq_d    = {2'b00, hid_Y, frc_Y, 1'b0};
      acc_d   = '0;
      cnt_d   = '0;
      tag_d   = in_tag;
    end
  end

  assign unused_prod_hi = ^prod_full[2*PW-2:2*MANT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Directed and randomized checks of the Booth multiplier: products against
// hand-computed constants or a plain integer multiply, latency, backpressure, reset.
module tb_fp_mul_booth_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        hid_X;
  logic [22:0] frc_X;
  logic        hid_Y;
  logic [22:0] frc_Y;
  logic [19:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] frc_Z_full;
  logic        norm_n;
  logic [19:0] out_tag;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_mul_booth_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hid_X      (hid_X),
    .frc_X      (frc_X),
    .hid_Y      (hid_Y),
    .frc_Y      (frc_Y),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frc_Z_full (frc_Z_full),
    .norm_n     (norm_n),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  typedef struct {
    logic        hx;
    logic [22:0] fx;
    logic        hy;
    logic [22:0] fy;
    logic [47:0] prod;
    logic        nrm;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic hx, input logic [22:0] fx, input logic hy,
                       input logic [22:0] fy, input logic [19:0] tag);
    hid_X  = hx;
    frc_X  = fx;
    hid_Y  = hy;
    frc_Y  = fy;
    in_tag = tag;
  endtask

  // Called just after the accept edge; returns edges until out_valid rises.
  task automatic wait_result(output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!out_valid && k < 40);
  endtask

  task automatic run_op(input string nm, input logic hx, input logic [22:0] fx,
                        input logic hy, input logic [22:0] fy, input logic [19:0] tag,
                        input logic [47:0] prod, input logic nrm, input int stall);
    int k;
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    drive(hx, fx, hy, fy, tag);
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(k);
    chk({nm, "_latency"}, 64'(k), 64'd13);
    chk({nm, "_prod"}, 64'(frc_Z_full), 64'(prod));
    chk({nm, "_norm"}, 64'(norm_n), 64'(nrm));
    chk({nm, "_tag"}, 64'(out_tag), 64'(tag));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      chk({nm, "_hold"}, {14'd0, out_valid, in_ready, frc_Z_full},
          {14'd0, 1'b1, 1'b0, prod});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, "_consumed"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [47:0] model;
    logic [23:0] mx;
    logic [23:0] my;
    logic [19:0] rtag;
    int          k;

    vecs[0] = '{1'b1, 23'h000000, 1'b1, 23'h000000, 48'h4000_0000_0000, 1'b0};
    vecs[1] = '{1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 48'hFFFF_FE00_0001, 1'b1};
    vecs[2] = '{1'b1, 23'h400000, 1'b1, 23'h400000, 48'h9000_0000_0000, 1'b1};
    vecs[3] = '{1'b0, 23'h000001, 1'b1, 23'h000000, 48'h0000_0080_0000, 1'b0};
    vecs[4] = '{1'b0, 23'h000000, 1'b1, 23'h7FFFFF, 48'h0000_0000_0000, 1'b0};
    vecs[5] = '{1'b1, 23'h000000, 1'b1, 23'h123456, 48'h491A_2B00_0000, 1'b0};
    vecs[6] = '{1'b1, 23'h000001, 1'b1, 23'h000001, 48'h4000_0100_0001, 1'b0};
    vecs[7] = '{1'b1, 23'h7FFFFF, 1'b1, 23'h000000, 48'h7FFF_FF80_0000, 1'b0};
    vecs[8] = '{1'b0, 23'h000003, 1'b0, 23'h000007, 48'h0000_0000_0015, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 23'h0, 1'b0, 23'h0, 20'h0);
    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_prod", 64'(frc_Z_full), 64'd0);
    chk("reset_norm", 64'(norm_n), 64'd0);
    chk("reset_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].hx, vecs[i].fx, vecs[i].hy, vecs[i].fy,
             20'(i * 37 + 5), vecs[i].prod, vecs[i].nrm, 0);
      if (i == 5) chk("one_times_y_field", 64'(frc_Z_full[45:23]), 64'(vecs[5].fy));
    end

    // Five cycles of backpressure, then a back-to-back accept on the release edge.
    run_op("bp_hold", 1'b1, 23'h400000, 1'b1, 23'h400000, 20'hABCDE,
           48'h9000_0000_0000, 1'b1, 0);
    drive(1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 20'h12345);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(k);
    chk("bp_first_latency", 64'(k), 64'd13);
    for (int s = 0; s < 5; s++) begin
      @(posedge clk);
      #1;
      chk("bp_stable", {11'd0, out_valid, in_ready, out_tag[2:0], frc_Z_full},
          {11'd0, 1'b1, 1'b0, 3'h5, 48'hFFFF_FE00_0001});
      chk("bp_tag_stable", 64'(out_tag), 64'h12345);
    end
    drive(1'b1, 23'h000001, 1'b1, 23'h000001, 20'h0BEEF);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_busy", {62'd0, out_valid, busy}, 64'd1);
    wait_result(k);
    chk("b2b_latency", 64'(k), 64'd13);
    chk("b2b_prod", 64'(frc_Z_full), 64'h4000_0100_0001);
    chk("b2b_tag", 64'(out_tag), 64'h0BEEF);
    @(posedge clk);
    #1;

    // Reset during the sixth BUSY cycle aborts the operation.
    drive(1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 20'h77777);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    chk("midreset_prod", 64'(frc_Z_full), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_reset", 1'b1, 23'h400000, 1'b1, 23'h400000, 20'h00042,
           48'h9000_0000_0000, 1'b1, 0);

    // Random operands and stalls against an integer-multiply model.
    for (int r = 0; r < 300; r++) begin
      mx    = {1'($urandom_range(0, 1)), 23'($urandom)};
      my    = {1'($urandom_range(0, 1)), 23'($urandom)};
      rtag  = 20'($urandom);
      model = 48'(mx) * 48'(my);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run_op($sformatf("rnd%0d", r), mx[23], mx[22:0], my[23], my[22:0], rtag, model,
             model[47], int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
